// File: rtl/backtrack_unit_pkg.sv
// backtrack_unit_pkg: shared widths, decider stack entry and backtrack FSM states
package backtrack_unit_pkg;
  localparam int MAX_VARS_BITS = 9;
  localparam int LEVEL_BITS = MAX_VARS_BITS + 1;
  typedef struct packed {
    logic [MAX_VARS_BITS-1:0] var_idx;
    logic                     val;
    logic                     flipped;
  } dec_entry_t;
  typedef enum logic [2:0] {IDLE, UNDO_IMPL, UNDO_DEC, FLIP, DONE, UNSAT} bt_state_t;
endpackage

// File: rtl/backtrack_unit.sv
// backtrack_unit: on conflict, unwinds implications and decisions, flipping the newest unflipped decision
module backtrack_unit
  import backtrack_unit_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEVEL_BITS-1:0]    dec_depth,
  input  logic                     imply_empty,
  input  logic [MAX_VARS_BITS-1:0] imply_top_var,
  input  logic [LEVEL_BITS-1:0]    imply_top_level,
  output logic                     imply_pop,
  input  logic                     dec_empty,
  input  dec_entry_t               dec_top,
  output logic                     dec_pop,
  output logic                     dec_push,
  output dec_entry_t               dec_push_data,
  output logic                     unassign_en,
  output logic [MAX_VARS_BITS-1:0] unassign_var,
  output logic                     assign_en,
  output logic [MAX_VARS_BITS-1:0] assign_var,
  output logic                     assign_val,
  output logic                     busy,
  output logic                     done,
  output logic                     unsat
);
  bt_state_t state_q, state_d;
  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic [MAX_VARS_BITS-1:0] var_q, var_d;
  logic val_q, val_d, unsat_q, unsat_d, impl_hit;
  assign impl_hit = !imply_empty && imply_top_level == level_q;
  always_ff @(posedge clock)
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
      var_q   <= '0;
      val_q   <= 1'b0;
      unsat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      var_q   <= var_d;
      val_q   <= val_d;
      unsat_q <= unsat_d;
    end
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    var_d         = var_q;
    val_d         = val_q;
    unsat_d       = unsat_q;
    imply_pop     = 1'b0;
    dec_pop       = 1'b0;
    dec_push      = 1'b0;
    dec_push_data = '0;
    unassign_en   = 1'b0;
    unassign_var  = '0;
    assign_en     = 1'b0;
    assign_var    = '0;
    assign_val    = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        level_d = dec_depth;
        state_d = UNDO_IMPL;
      end
      UNDO_IMPL: if (impl_hit) begin
        imply_pop    = 1'b1;
        unassign_en  = 1'b1;
        unassign_var = imply_top_var;
      end else state_d = UNDO_DEC;
      UNDO_DEC: if (dec_empty) begin
        unsat_d = 1'b1;
        state_d = UNSAT;
      end else begin
        dec_pop      = 1'b1;
        unassign_en  = 1'b1;
        unassign_var = dec_top.var_idx;
        level_d      = dec_top.flipped ? level_q - LEVEL_BITS'(1) : level_q;
        var_d        = dec_top.flipped ? var_q : dec_top.var_idx;
        val_d        = dec_top.flipped ? val_q : dec_top.val;
        state_d      = dec_top.flipped ? UNDO_IMPL : FLIP;
      end
      // pop happened last cycle, so this push keeps the stack depth unchanged
      FLIP: begin
        dec_push      = 1'b1;
        dec_push_data = '{var_q, ~val_q, 1'b1};
        assign_en     = 1'b1;
        assign_var    = var_q;
        assign_val    = ~val_q;
        state_d       = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      UNSAT: state_d = UNSAT;
      default: state_d = IDLE;
    endcase
  end
  assign busy  = state_q != IDLE && state_q != UNSAT;
  assign unsat = unsat_q;
endmodule

// File: tb/tb_backtrack_unit.sv
// tb_backtrack_unit: queue-modelled stacks around the DUT, checked against an abstract backtrack model
module tb_backtrack_unit;
  import backtrack_unit_pkg::*;
  typedef struct {
    logic [MAX_VARS_BITS-1:0] v;
    logic [LEVEL_BITS-1:0]    l;
  } ient_t;
  logic clock, reset, start, imply_empty, dec_empty;
  logic [LEVEL_BITS-1:0] dec_depth, imply_top_level;
  logic [MAX_VARS_BITS-1:0] imply_top_var;
  dec_entry_t dec_top, dec_push_data;
  logic imply_pop, dec_pop, dec_push, unassign_en, assign_en, assign_val, busy, done, unsat;
  logic [MAX_VARS_BITS-1:0] unassign_var, assign_var;
  ient_t imq[$], mi[$];
  dec_entry_t dq[$], md[$];
  logic [MAX_VARS_BITS-1:0] ou[$], eu[$];
  int checks = 0, errors = 0;
  int cyc, dones, pushes, strobes, done_cyc, unsat_cyc, e_lat;
  bit e_unsat;
  dec_entry_t e_push, o_push;

  backtrack_unit dut (
    .clock(clock), .reset(reset), .start(start), .dec_depth(dec_depth),
    .imply_empty(imply_empty), .imply_top_var(imply_top_var), .imply_top_level(imply_top_level),
    .imply_pop(imply_pop), .dec_empty(dec_empty), .dec_top(dec_top), .dec_pop(dec_pop),
    .dec_push(dec_push), .dec_push_data(dec_push_data), .unassign_en(unassign_en),
    .unassign_var(unassign_var), .assign_en(assign_en), .assign_var(assign_var),
    .assign_val(assign_val), .busy(busy), .done(done), .unsat(unsat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dec_entry_t ent(input int v, input bit val, input bit f);
    return '{v[MAX_VARS_BITS-1:0], val, f};
  endfunction

  function automatic ient_t ie(input int v, input int l);
    return '{v[MAX_VARS_BITS-1:0], l[LEVEL_BITS-1:0]};
  endfunction

  task automatic drive();
    imply_empty     = imq.size() == 0;
    imply_top_var   = imq.size() ? imq[$].v : '0;
    imply_top_level = imq.size() ? imq[$].l : '0;
    dec_empty       = dq.size() == 0;
    dec_top         = dq.size() ? dq[$] : '0;
  endtask

  task automatic tick();
    logic ip, dp, pu;
    dec_entry_t pd;
    @(negedge clock);
    ip = imply_pop; dp = dec_pop; pu = dec_push; pd = dec_push_data;
    if (ip | dp | pu | unassign_en | assign_en) begin
      strobes++;
      chk("pops_exclusive", {31'd0, ip & dp}, 0);
      chk("pop_push_exclusive", {31'd0, dp & pu}, 0);
      chk("imply_pop_nonempty", {31'd0, ip & imply_empty}, 0);
      chk("dec_pop_nonempty", {31'd0, dp & dec_empty}, 0);
      chk("unassign_with_pop", {31'd0, unassign_en}, {31'd0, ip | dp});
      chk("assign_with_push", {31'd0, assign_en}, {31'd0, pu});
      if (pu) chk("assign_matches_push", {assign_var, assign_val}, {pd.var_idx, pd.val});
      if (unassign_en) ou.push_back(unassign_var);
    end
    if (pu) begin pushes++; o_push = pd; end
    if (done) begin dones++; if (done_cyc < 0) done_cyc = cyc; end
    if (unsat && unsat_cyc < 0) unsat_cyc = cyc;
    @(posedge clock); #1;
    if (ip && imq.size()) void'(imq.pop_back());
    if (dp && dq.size()) void'(dq.pop_back());
    if (pu) dq.push_back(pd);
    cyc++;
    drive();
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clock);
    chk(tag, {imply_pop, dec_pop, dec_push, unassign_en, assign_en, busy, done, unsat}, 0);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // Abstract backtrack: strip current-level implications, discard flipped decisions, flip the first unflipped one
  task automatic model(input int depth);
    int lvl, t;
    dec_entry_t top;
    lvl = depth; t = 0; mi = imq; md = dq; eu.delete(); e_unsat = 0; e_push = '0;
    forever begin
      while (mi.size() && int'(mi[$].l) == lvl) begin
        eu.push_back(mi[$].v); void'(mi.pop_back()); t++;
      end
      t += 2;
      if (md.size() == 0) begin e_unsat = 1; e_lat = t + 1; break; end
      top = md.pop_back();
      eu.push_back(top.var_idx);
      if (top.flipped) begin lvl--; continue; end
      e_push = '{top.var_idx, ~top.val, 1'b1};
      md.push_back(e_push);
      e_lat = t + 2;
      break;
    end
  endtask

  task automatic run(input string tag, input int depth, input bit rep);
    model(depth);
    ou.delete(); dones = 0; pushes = 0; strobes = 0; done_cyc = -1; unsat_cyc = -1; cyc = 0;
    drive();
    dec_depth = depth[LEVEL_BITS-1:0];
    start = 1'b1;
    tick();
    if (!rep) start = 1'b0;
    while (done_cyc < 0 && unsat_cyc < 0 && cyc < 300) tick();
    start = 1'b0;
    tick(); tick();
    chk({tag, ".finished"}, {31'd0, done_cyc >= 0 || unsat_cyc >= 0}, 1);
    chk({tag, ".latency"}, e_unsat ? unsat_cyc : done_cyc, e_lat);
    chk({tag, ".unsat"}, {31'd0, unsat}, {31'd0, e_unsat});
    chk({tag, ".done_pulses"}, dones, e_unsat ? 0 : 1);
    chk({tag, ".pushes"}, pushes, e_unsat ? 0 : 1);
    chk({tag, ".busy_after"}, {31'd0, busy}, 0);
    if (!e_unsat) chk({tag, ".push_data"}, o_push, e_push);
    chk({tag, ".unassign_count"}, ou.size(), eu.size());
    for (int i = 0; i < ou.size() && i < eu.size(); i++)
      chk($sformatf("%s.unassign%0d", tag, i), ou[i], eu[i]);
    chk({tag, ".imply_left"}, imq.size(), mi.size());
    for (int i = 0; i < imq.size() && i < mi.size(); i++)
      chk($sformatf("%s.imply%0d", tag, i), {imq[i].v, imq[i].l}, {mi[i].v, mi[i].l});
    chk({tag, ".dec_left"}, dq.size(), md.size());
    for (int i = 0; i < dq.size() && i < md.size(); i++)
      chk($sformatf("%s.dec%0d", tag, i), dq[i], md[i]);
  endtask

  task automatic setup_normal();
    imq.delete(); dq.delete();
    dq.push_back(ent(1, 0, 0)); dq.push_back(ent(2, 1, 0));
    imq.push_back(ie(5, 1)); imq.push_back(ie(7, 2)); imq.push_back(ie(9, 2));
  endtask

  initial begin
    int d, n;
    reset = 1'b0; start = 1'b0; dec_depth = '0;
    drive();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    check_quiet("reset_state");

    setup_normal();
    run("normal", 2, 0);
    chk("normal.done_cycle6", done_cyc, 6);

    do_reset();
    setup_normal();
    run("start_while_busy", 2, 1);

    do_reset();
    imq.delete(); dq.delete();
    dq.push_back(ent(1, 0, 0)); dq.push_back(ent(2, 1, 1));
    imq.push_back(ie(5, 1)); imq.push_back(ie(9, 2));
    run("flipped_top", 2, 0);

    do_reset();
    imq.delete(); dq.delete();
    dq.push_back(ent(1, 1, 1));
    imq.push_back(ie(3, 1));
    run("unsat", 1, 0);
    strobes = 0;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    chk("unsat.later_start_strobes", strobes, 0);
    chk("unsat.held", {31'd0, unsat}, 1);
    chk("unsat.busy", {31'd0, busy}, 0);

    do_reset();
    imq.delete(); dq.delete();
    run("empty_start", 0, 0);
    chk("empty_start.unsat_cycle3", unsat_cyc, 3);

    do_reset();
    setup_normal();
    drive();
    dec_depth = 2;
    cyc = 0; ou.delete(); strobes = 0; dones = 0; pushes = 0; done_cyc = -1; unsat_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_quiet("reset_mid.quiet");
    run("reset_mid.restart", 2, 0);

    for (int s = 0; s < 20; s++) begin
      do_reset();
      imq.delete(); dq.delete();
      d = $urandom_range(0, 4);
      for (int l = 1; l <= d; l++) begin
        dq.push_back(ent($urandom_range(0, 511), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
        n = $urandom_range(0, 2);
        repeat (n) imq.push_back(ie($urandom_range(0, 511), l));
      end
      run($sformatf("rnd%0d", s), d, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
